mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles to wait for m_ack (range 1..65535).
REQ-002 SHALL have parameter DBG_PRIORITY, default 1; 1 = debug wins simultaneous requests, 0 = CPU wins.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 n_reset  in  1  reset, asynchronous assert, active-low.
REQ-005 cpu_valid  in  1  CPU request; held high until cpu_ready.
REQ-006 cpu_addr  in  32  CPU word address (bits [1:0] passed through).
REQ-007 cpu_wdata  in  32  CPU write data.
REQ-008 cpu_wstrb  in  4  CPU byte strobes; 0000 = read.
REQ-009 cpu_rdata  out  32  CPU read data, valid with cpu_ready.
REQ-010 cpu_ready  out  1  one-cycle completion pulse to CPU.
REQ-011 dbg_req  in  1  debug request, single-cycle pulse.
REQ-012 dbg_rw  in  1  1 = read, 0 = write; sampled with dbg_req.
REQ-013 dbg_addr  in  32  debug address, sampled with dbg_req.
REQ-014 dbg_wdata  in  32  debug write data, sampled with dbg_req.
REQ-015 dbg_rdata  out  32  debug read data, valid with dbg_done.
REQ-016 dbg_done  out  1  one-cycle completion pulse to debug unit.
REQ-017 m_req  out  1  memory request, held until m_ack.
REQ-018 m_we  out  1  memory write enable.
REQ-019 m_addr / m_wdata / m_wstrb  out  32/32/4  memory address, data, strobes (one line per signal in RTL).
REQ-020 m_rdata  in  32  memory read data, valid with m_ack.
REQ-021 m_ack  in  1  memory completion, one-cycle pulse.

Function
REQ-022 SHALL latch dbg_req/rw/addr/wdata into a one-entry pending buffer; a dbg_req arriving while the buffer is full SHALL be dropped (debug protocol guarantees one outstanding op).
REQ-023 FSM states: IDLE, CPU_XFER, DBG_XFER, DONE; one grant per transfer, no preemption.
REQ-024 IDLE: if pending-debug and cpu_valid, winner by DBG_PRIORITY unless last grant went to that side, then the other side wins (alternating on contention); else the sole requester wins; transition next cycle.
REQ-025 Grant SHALL drive m_req=1 and m_addr/m_wdata/m_wstrb from the winner; debug write uses m_wstrb=1111, debug read 0000; m_we = |m_wstrb.
REQ-026 In *_XFER, m_ack SHALL deassert m_req same edge, capture m_rdata, pulse cpu_ready or dbg_done next cycle (DONE), then return to IDLE.
REQ-027 Minimum latency request-to-completion with m_ack in first cycle: 3 clk; back-to-back grants SHALL have one IDLE cycle between.
REQ-028 cpu_rdata/dbg_rdata SHALL hold last captured value until next completion for that side.
REQ-029 Pending-debug buffer SHALL clear on the cycle the debug grant is issued; a new dbg_req same cycle SHALL be accepted.
REQ-030 m_ack while not in *_XFER SHALL be ignored.

Reset
REQ-031 On n_reset low: FSM IDLE, pending buffer empty, last-grant = CPU, all outputs 0 (m_req, m_we, cpu_ready, dbg_done, buses, rdata).
REQ-032 Reset mid-transfer SHALL abandon it with no completion pulse; release resumes in IDLE next edge.

Configuration
REQ-033 Macro MEM_ARB_TIMEOUT_EN: when defined, a 16-bit counter SHALL abort an *_XFER after TIMEOUT_CYCLES without m_ack, drop m_req, return rdata 32'hDEADBEEF with a normal completion pulse; when undefined, no counter exists and the FSM waits indefinitely.

Structure
REQ-034 Shared package mem_arb_pkg SHALL hold FSM state enum, owner enum (OWN_CPU, OWN_DBG) and constant TIMEOUT_RDATA = 32'hDEADBEEF.
REQ-035 Sub-module mem_arb_dbgbuf SHALL implement the one-entry pending-debug buffer; arbitration and FSM stay in mem_arb.

Verification
REQ-036 CPU read 0x100, m_ack after 2 cycles with 0xCAFEF00D -> single cpu_ready pulse, cpu_rdata=0xCAFEF00D, dbg_done never.
REQ-037 dbg_req write 0x200 data 0x12345678 -> m_we=1, m_wstrb=1111, m_addr=0x200, one dbg_done pulse.
REQ-038 cpu_valid and dbg_req same cycle, DBG_PRIORITY=1, continuous traffic -> grants DBG, CPU, DBG, CPU alternating.
REQ-039 n_reset low during DBG_XFER -> m_req=0 immediately, no dbg_done, buffer empty after release.
REQ-040 MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, no m_ack -> m_req drops after 4 cycles, cpu_ready with cpu_rdata=0xDEADBEEF.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/debug memory arbiter: FSM states, grant owner, debug op record
// and the read data returned when a transfer is abandoned by the watchdog.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CPU_XFER = 2'd1,
        ST_DBG_XFER = 2'd2,
        ST_DONE     = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dbg_op_t;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;
    localparam logic [3:0]  STRB_ALL      = 4'b1111;
    localparam logic [3:0]  STRB_NONE     = 4'b0000;

    // Under contention the preferred side wins unless it also took the previous grant.
    function automatic owner_e pick_winner(input logic   cpu_req,
                                           input logic   dbg_req,
                                           input owner_e last,
                                           input logic   dbg_prio);
        owner_e pref;
        owner_e other;
        pref  = dbg_prio ? OWN_DBG : OWN_CPU;
        other = dbg_prio ? OWN_CPU : OWN_DBG;
        if (cpu_req && dbg_req) begin
            pick_winner = (last == pref) ? other : pref;
        end else if (dbg_req) begin
            pick_winner = OWN_DBG;
        end else begin
            pick_winner = OWN_CPU;
        end
    endfunction

endpackage

// File: rtl/mem_arb_dbgbuf.sv
// One-entry pending buffer for debug operations; the head is either the stored op or,
// when empty, the op arriving this cycle so an idle arbiter can grant it immediately.
module mem_arb_dbgbuf
    import mem_arb_pkg::*;
(
    input  logic    clk_i,
    input  logic    n_reset_i,
    input  logic    req_i,
    input  dbg_op_t op_i,
    input  logic    take_i,
    output logic    pend_o,
    output dbg_op_t op_o
);

    logic    valid_q;
    logic    valid_d;
    dbg_op_t op_q;
    dbg_op_t op_d;

    assign pend_o = valid_q | req_i;
    assign op_o   = valid_q ? op_q : op_i;

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        if (take_i) begin
            // Consuming a stored head frees the slot for an op arriving in the same cycle.
            valid_d = valid_q & req_i;
            if (valid_q && req_i) begin
                op_d = op_i;
            end
        end else if (!valid_q && req_i) begin
            valid_d = 1'b1;
            op_d    = op_i;
        end
    end

    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            valid_q <= 1'b0;
            op_q    <= '0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates a CPU port and a debug port onto one memory port, one transfer per grant.
// Build macro MEM_ARB_TIMEOUT_EN adds a watchdog that completes a stalled transfer with TIMEOUT_RDATA.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          DBG_PRIORITY   = 1'b1
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        cpu_valid,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    input  logic        dbg_req,
    input  logic        dbg_rw,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata,
    output logic        dbg_done,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output arb_state_e  fsm_state
);

    // Handshakes: cpu_valid is held until the one-cycle cpu_ready pulse; dbg_req is a one-cycle
    // pulse answered by a one-cycle dbg_done; m_req is held until the one-cycle m_ack.

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mem_arb: TIMEOUT_CYCLES must be in 1..65535");
    end

    arb_state_e  state_q, state_d;
    owner_e      last_q, last_d;
    logic        m_req_q, m_req_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [3:0]  m_wstrb_q, m_wstrb_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] dbg_rdata_q, dbg_rdata_d;
    logic        cpu_ready_q, cpu_ready_d;
    logic        dbg_done_q, dbg_done_d;

    logic        dbg_pend;
    dbg_op_t     dbg_in;
    dbg_op_t     dbg_head;
    logic        dbg_take;
    owner_e      win;
    logic        xfer_end;
    logic [31:0] end_rdata;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_cnt_q, wd_cnt_d;
`endif

    assign dbg_in = '{rw: dbg_rw, addr: dbg_addr, wdata: dbg_wdata};

    mem_arb_dbgbuf u_dbgbuf (
        .clk_i     (clk),
        .n_reset_i (n_reset),
        .req_i     (dbg_req),
        .op_i      (dbg_in),
        .take_i    (dbg_take),
        .pend_o    (dbg_pend),
        .op_o      (dbg_head)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        m_req_d     = m_req_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_wstrb_d   = m_wstrb_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        cpu_ready_d = 1'b0;
        dbg_done_d  = 1'b0;
        dbg_take    = 1'b0;
        win         = OWN_CPU;
        xfer_end    = 1'b0;
        end_rdata   = m_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
        wd_cnt_d    = wd_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cpu_valid || dbg_pend) begin
                    win     = pick_winner(cpu_valid, dbg_pend, last_q, DBG_PRIORITY);
                    last_d  = win;
                    m_req_d = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                    wd_cnt_d = 16'd0;
`endif
                    if (win == OWN_DBG) begin
                        dbg_take  = 1'b1;
                        m_addr_d  = dbg_head.addr;
                        m_wdata_d = dbg_head.wdata;
                        m_wstrb_d = dbg_head.rw ? STRB_NONE : STRB_ALL;
                        state_d   = ST_DBG_XFER;
                    end else begin
                        m_addr_d  = cpu_addr;
                        m_wdata_d = cpu_wdata;
                        m_wstrb_d = cpu_wstrb;
                        state_d   = ST_CPU_XFER;
                    end
                end
            end
            ST_CPU_XFER, ST_DBG_XFER: begin
                if (m_ack) begin
                    xfer_end = 1'b1;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wd_cnt_q == WD_LAST) begin
                    xfer_end  = 1'b1;
                    end_rdata = TIMEOUT_RDATA;
                end else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
                end
`endif
                if (xfer_end) begin
                    m_req_d = 1'b0;
                    state_d = ST_DONE;
                    if (state_q == ST_CPU_XFER) begin
                        cpu_rdata_d = end_rdata;
                        cpu_ready_d = 1'b1;
                    end else begin
                        dbg_rdata_d = end_rdata;
                        dbg_done_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= ST_IDLE;
            last_q      <= OWN_CPU;
            m_req_q     <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            m_wstrb_q   <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            dbg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            m_req_q     <= m_req_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_wstrb_q   <= m_wstrb_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            dbg_done_q  <= dbg_done_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wd_cnt_q <= 16'd0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`endif

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign dbg_rdata = dbg_rdata_q;
    assign dbg_done  = dbg_done_q;
    assign m_req     = m_req_q;
    assign m_we      = |m_wstrb_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_wstrb   = m_wstrb_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: memory responder model, per-port expected queues, summary line.
module tb_mem_arb;
    import mem_arb_pkg::*;

    localparam int TO_CYC = 4;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        cpu_valid, dbg_req, dbg_rw, m_req, m_we, m_ack, cpu_ready, dbg_done;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dbg_addr, dbg_wdata, dbg_rdata;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  cpu_wstrb, m_wstrb;
    arb_state_e  fsm_state;

    int          n_vec = 0;
    int          n_miss = 0;
    logic [31:0] exp_cpu_q[$];
    logic [31:0] exp_dbg_q[$];
    logic [67:0] exp_mem_q[$];
    int          ack_delay = 0;
    bit          resp_en = 1'b1;
    bit          stray_ack = 1'b0;
    int          wait_cnt = 0;

    mem_arb #(.TIMEOUT_CYCLES(TO_CYC), .DBG_PRIORITY(1'b1)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .cpu_valid (cpu_valid),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wstrb (cpu_wstrb),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .dbg_req   (dbg_req),
        .dbg_rw    (dbg_rw),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_rdata (dbg_rdata),
        .dbg_done  (dbg_done),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_rdata   (m_rdata),
        .m_ack     (m_ack),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hCAFEF00D;
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic push_mem(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        exp_mem_q.push_back({ws, wd, a});
    endtask

    task automatic mem_check();
        logic [67:0] e;
        if (exp_mem_q.size() == 0) begin
            check("unexp_m_req", 32'(m_req), 32'd0);
        end else begin
            e = exp_mem_q.pop_front();
            check("m_addr", m_addr, e[31:0]);
            check("m_wstrb", 32'(m_wstrb), 32'(e[67:64]));
            check("m_we", 32'(m_we), 32'(|e[67:64]));
            if (|e[67:64]) check("m_wdata", m_wdata, e[63:32]);
        end
    endtask

    // ---------------- memory responder ----------------
    initial begin
        m_ack = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            m_ack = 1'b0;
            if (stray_ack) begin
                m_ack = 1'b1;
                m_rdata = 32'h0BAD0BAD;
            end else if (m_req && resp_en) begin
                if (wait_cnt >= ack_delay) begin
                    mem_check();
                    m_ack = 1'b1;
                    m_rdata = mem_word(m_addr);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (n_reset) begin
            if (cpu_ready) begin
                if (exp_cpu_q.size() == 0) check("unexp_cpu_ready", 32'(cpu_ready), 32'd0);
                else check("cpu_rdata", cpu_rdata, exp_cpu_q.pop_front());
            end
            if (dbg_done) begin
                if (exp_dbg_q.size() == 0) check("unexp_dbg_done", 32'(dbg_done), 32'd0);
                else check("dbg_rdata", dbg_rdata, exp_dbg_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        n_reset = 1'b0;
        cpu_valid = 1'b0;
        dbg_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 n_reset = 1'b1;
    endtask

    task automatic cpu_xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                            input logic [31:0] exp_rd, output int lat);
        bit seen;
        exp_cpu_q.push_back(exp_rd);
        @(posedge clk);
        #1;
        cpu_valid = 1'b1;
        cpu_addr = a;
        cpu_wdata = wd;
        cpu_wstrb = ws;
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (cpu_ready) seen = 1'b1;
        end
        if (!seen) check("cpu_ready_wait", 32'(cpu_ready), 32'd1);
    endtask

    task automatic cpu_release();
        @(posedge clk);
        #1;
        cpu_valid = 1'b0;
        cpu_wstrb = 4'h0;
    endtask

    task automatic wait_dbg_done(inout int lat);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (dbg_done) seen = 1'b1;
        end
        if (!seen) check("dbg_done_wait", 32'(dbg_done), 32'd1);
    endtask

    task automatic dbg_xfer(input logic rw, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] exp_rd, output int lat);
        exp_dbg_q.push_back(exp_rd);
        @(posedge clk);
        #1;
        dbg_req = 1'b1;
        dbg_rw = rw;
        dbg_addr = a;
        dbg_wdata = wd;
        @(posedge clk);
        #1;
        dbg_req = 1'b0;
        lat = 1;
        wait_dbg_done(lat);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          lat;
        int          lat2;
        int          hi;
        bit          seen;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [31:0] last_cpu;

        cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        dbg_req = 1'b0; dbg_rw = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        apply_reset();

        @(negedge clk);
        check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
        check("rst_m_req", 32'(m_req), 32'd0);
        check("rst_m_we", 32'(m_we), 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_dbg_done", 32'(dbg_done), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_dbg_rdata", dbg_rdata, 32'd0);

        // CPU read with a two-cycle memory delay
        ack_delay = 2;
        push_mem(32'h100, 32'h0, 4'h0);
        cpu_xfer(32'h100, 32'h0, 4'h0, 32'hCAFEF00D, lat);
        cpu_release();
        check("cpu_lat_d2", lat, 5);

        // Minimum latency CPU write with partial strobes
        ack_delay = 0;
        push_mem(32'h104, 32'h0000_00AA, 4'b0011);
        cpu_xfer(32'h104, 32'h0000_00AA, 4'b0011, mem_word(32'h104), lat);
        cpu_release();
        check("cpu_lat_min", lat, 3);
        last_cpu = mem_word(32'h104);

        // Debug write and read
        push_mem(32'h200, 32'h12345678, 4'hF);
        dbg_xfer(1'b0, 32'h200, 32'h12345678, mem_word(32'h200), lat);
        check("dbg_lat_min", lat, 3);
        check("cpu_rdata_hold", cpu_rdata, last_cpu);
        ack_delay = 1;
        push_mem(32'h208, 32'h0, 4'h0);
        dbg_xfer(1'b1, 32'h208, 32'hFFFF_0000, mem_word(32'h208), lat);

        // Random CPU traffic with varying memory delay
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            wd = $urandom;
            ws = 4'($urandom_range(0, 15));
            ack_delay = $urandom_range(0, 3);
            push_mem(a, wd, ws);
            cpu_xfer(a, wd, ws, mem_word(a), lat);
            cpu_release();
            check("cpu_lat_rand", lat, 3 + ack_delay);
            last_cpu = mem_word(a);
        end
        check("dbg_rdata_hold", dbg_rdata, mem_word(32'h208));

        // Stray m_ack in IDLE is ignored
        @(negedge clk); stray_ack = 1'b1;
        @(negedge clk); stray_ack = 1'b0;
        @(negedge clk);
        check("stray_state", 32'(fsm_state), 32'(ST_IDLE));
        check("stray_m_req", 32'(m_req), 32'd0);
        check("stray_cpu_rdata", cpu_rdata, last_cpu);
        check("stray_dbg_rdata", dbg_rdata, mem_word(32'h208));

        // Second debug request while the buffer is full is dropped
        ack_delay = 3;
        push_mem(32'h500, 32'h0, 4'h0);
        push_mem(32'h600, 32'h0, 4'h0);
        fork
            begin
                cpu_xfer(32'h500, 32'h0, 4'h0, mem_word(32'h500), lat);
                cpu_release();
            end
            begin
                exp_dbg_q.push_back(mem_word(32'h600));
                @(posedge clk);
                @(posedge clk);
                #1 dbg_req = 1'b1; dbg_rw = 1'b1; dbg_addr = 32'h600;
                @(posedge clk);
                #1 dbg_rw = 1'b0; dbg_addr = 32'h700; dbg_wdata = 32'h77;
                @(posedge clk);
                #1 dbg_req = 1'b0;
                lat2 = 0;
                wait_dbg_done(lat2);
            end
        join
        repeat (8) @(negedge clk);
        check("drop_mem_q", 32'(exp_mem_q.size()), 32'd0);

        // Reset in the middle of a debug transfer, with a second op buffered
        resp_en = 1'b0;
        @(posedge clk);
        #1 dbg_req = 1'b1; dbg_rw = 1'b0; dbg_addr = 32'h400; dbg_wdata = 32'h4444;
        @(posedge clk);
        #1 dbg_addr = 32'h404;
        @(negedge clk);
        check("rstx_state", 32'(fsm_state), 32'(ST_DBG_XFER));
        check("rstx_m_req", 32'(m_req), 32'd1);
        @(posedge clk);
        #1 dbg_req = 1'b0;
        #1 n_reset = 1'b0;
        #1;
        check("rstx_m_req_drop", 32'(m_req), 32'd0);
        check("rstx_state_idle", 32'(fsm_state), 32'(ST_IDLE));
        repeat (2) @(posedge clk);
        #1 n_reset = 1'b1;
        resp_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rstx_no_req", 32'(m_req), 32'd0);
        end

        // Contention straight after reset: DBG, CPU, DBG, CPU
        ack_delay = 1;
        push_mem(32'h800, 32'hD0D0_0001, 4'hF);
        push_mem(32'h900, 32'h0, 4'h0);
        push_mem(32'h804, 32'hD0D0_0002, 4'hF);
        push_mem(32'h904, 32'h0, 4'h0);
        fork
            begin
                cpu_xfer(32'h900, 32'h0, 4'h0, mem_word(32'h900), lat);
                cpu_xfer(32'h904, 32'h0, 4'h0, mem_word(32'h904), lat);
                cpu_release();
            end
            begin
                dbg_xfer(1'b0, 32'h800, 32'hD0D0_0001, mem_word(32'h800), lat2);
                dbg_xfer(1'b0, 32'h804, 32'hD0D0_0002, mem_word(32'h804), lat2);
            end
        join
        repeat (4) @(negedge clk);
        check("alt_mem_q", 32'(exp_mem_q.size()), 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog completes a transfer that never sees m_ack
        resp_en = 1'b0;
        exp_cpu_q.push_back(32'hDEADBEEF);
        @(posedge clk);
        #1 cpu_valid = 1'b1; cpu_addr = 32'h300; cpu_wstrb = 4'h0;
        hi = 0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (m_req) hi++;
            if (cpu_ready) seen = 1'b1;
        end
        check("to_req_cycles", hi, TO_CYC);
        check("to_ready", 32'(seen), 32'd1);
        cpu_release();
        resp_en = 1'b1;
`endif

        repeat (5) @(negedge clk);
        check("end_cpu_q", 32'(exp_cpu_q.size()), 32'd0);
        check("end_dbg_q", 32'(exp_dbg_q.size()), 32'd0);
        check("end_mem_q", 32'(exp_mem_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
